// File: rtl/cam_tag_array_snoop.sv
// CAM tag array: per-entry set/clear, combinational multi-hit match and binary-address snoop.
// Each entry is its own instance; the top only gathers per-entry state into the snoop mux.
module cam_tag_array_snoop_entry #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               w_v_i,
  input  logic               w_set_not_clear_i,
  input  logic [width_p-1:0] w_tag_i,
  input  logic               r_v_i,
  input  logic [width_p-1:0] r_tag_i,
  output logic               valid_o,
  output logic [width_p-1:0] tag_o,
  output logic               match_o
);
  logic               valid_r;
  logic [width_p-1:0] tag_r;

  // A clear drops only the valid bit so the snoop port can still drain the old tag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_r <= 1'b0;
      tag_r   <= '0;
    end else if (w_v_i) begin
      valid_r <= w_set_not_clear_i;
      if (w_set_not_clear_i) tag_r <= w_tag_i;
    end
  end

  assign valid_o = valid_r;
  assign tag_o   = tag_r;
  assign match_o = r_v_i & valid_r & (tag_r == r_tag_i);
endmodule

module cam_tag_array_snoop #(
  parameter  int width_p   = 32,
  parameter  int els_p     = 16,
  localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [els_p-1:0]     w_v_i,
  input  logic                 w_set_not_clear_i,
  input  logic [width_p-1:0]   w_tag_i,
  output logic [els_p-1:0]     w_empty_o,
  input  logic                 r_v_i,
  input  logic [width_p-1:0]   r_tag_i,
  output logic [els_p-1:0]     r_match_o,
  input  logic [lg_els_lp-1:0] snoop_addr_i,
  output logic [width_p-1:0]   snoop_tag_o
);
  logic [els_p-1:0]              valid;
  logic [els_p-1:0][width_p-1:0] tags;

  for (genvar k = 0; k < els_p; k++) begin : g_el
    cam_tag_array_snoop_entry #(.width_p(width_p)) u_el (
      .clk_i             (clk_i),
      .reset_i           (reset_i),
      .w_v_i             (w_v_i[k]),
      .w_set_not_clear_i (w_set_not_clear_i),
      .w_tag_i           (w_tag_i),
      .r_v_i             (r_v_i),
      .r_tag_i           (r_tag_i),
      .valid_o           (valid[k]),
      .tag_o             (tags[k]),
      .match_o           (r_match_o[k])
    );
  end

  assign w_empty_o = ~valid;

  // Compare-select rather than index so out-of-range addresses fall through to zero.
  always_comb begin
    snoop_tag_o = '0;
    for (int k = 0; k < els_p; k++)
      if (snoop_addr_i == lg_els_lp'(k)) snoop_tag_o = tags[k];
  end
endmodule

// File: tb/tb_cam_tag_array_snoop.sv
// Directed bench for cam_tag_array_snoop: 4-entry array for the main flow, 3-entry for out-of-range snoop.
module tb_cam_tag_array_snoop;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_i;
  logic [3:0]   w_v_i;
  logic         w_set_not_clear_i;
  logic [W-1:0] w_tag_i;
  logic [3:0]   w_empty_o;
  logic         r_v_i;
  logic [W-1:0] r_tag_i;
  logic [3:0]   r_match_o;
  logic [1:0]   snoop_addr_i;
  logic [W-1:0] snoop_tag_o;

  logic [2:0]   w_v3;
  logic [2:0]   w_empty3;
  logic [2:0]   r_match3;
  logic [1:0]   snoop_addr3;
  logic [W-1:0] snoop_tag3;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cam_tag_array_snoop #(.width_p(W), .els_p(4)) u_dut (
    .clk_i(clk), .reset_i(reset_i), .w_v_i(w_v_i), .w_set_not_clear_i(w_set_not_clear_i),
    .w_tag_i(w_tag_i), .w_empty_o(w_empty_o), .r_v_i(r_v_i), .r_tag_i(r_tag_i),
    .r_match_o(r_match_o), .snoop_addr_i(snoop_addr_i), .snoop_tag_o(snoop_tag_o)
  );

  cam_tag_array_snoop #(.width_p(W), .els_p(3)) u_dut3 (
    .clk_i(clk), .reset_i(reset_i), .w_v_i(w_v3), .w_set_not_clear_i(w_set_not_clear_i),
    .w_tag_i(w_tag_i), .w_empty_o(w_empty3), .r_v_i(r_v_i), .r_tag_i(r_tag_i),
    .r_match_o(r_match3), .snoop_addr_i(snoop_addr3), .snoop_tag_o(snoop_tag3)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] fill_empty [4] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};

  initial begin
    reset_i = 1'b1; w_v_i = '0; w_set_not_clear_i = 1'b0; w_tag_i = '0;
    r_v_i = 1'b0; r_tag_i = '0; snoop_addr_i = '0; w_v3 = '0; snoop_addr3 = '0;
    tick(); tick();
    reset_i = 1'b0;

    // reset state
    r_v_i = 1'b1; r_tag_i = '0; snoop_addr_i = 2'd0; #1;
    chk("rst_empty", 32'(w_empty_o), 32'hF);
    chk("rst_match", 32'(r_match_o), 32'h0);
    chk("rst_snoop", 32'(snoop_tag_o), 32'h0);

    // fill one entry per cycle
    for (int i = 0; i < 4; i++) begin
      w_v_i = 4'(1 << i); w_set_not_clear_i = 1'b1; w_tag_i = W'(8'hA + i);
      tick();
      w_v_i = '0; #1;
      chk($sformatf("fill_empty%0d", i), 32'(w_empty_o), 32'(fill_empty[i]));
    end
    r_tag_i = 8'hC; #1; chk("hit_C", 32'(r_match_o), 32'b0100);
    r_tag_i = 8'hE; #1; chk("miss_E", 32'(r_match_o), 32'b0000);
    for (int i = 0; i < 4; i++) begin
      snoop_addr_i = 2'(i); #1;
      chk($sformatf("snoop%0d", i), 32'(snoop_tag_o), 32'hA + i);
    end

    // clear keeps tag
    w_v_i = 4'b0100; w_set_not_clear_i = 1'b0; tick(); w_v_i = '0; #1;
    chk("clr_empty", 32'(w_empty_o), 32'b0100);
    r_tag_i = 8'hC; #1; chk("clr_match", 32'(r_match_o), 32'b0000);
    snoop_addr_i = 2'd2; #1; chk("clr_snoop", 32'(snoop_tag_o), 32'hC);

    // write and lookup in the same cycle: no forwarding
    w_v_i = 4'b0100; w_set_not_clear_i = 1'b1; w_tag_i = 8'h5; r_tag_i = 8'h5; #1;
    chk("wr_rd_same", 32'(r_match_o), 32'b0000);
    tick(); w_v_i = '0; #1;
    chk("wr_rd_next", 32'(r_match_o), 32'b0100);

    // multi-hot set and duplicates
    w_v_i = 4'b0011; w_tag_i = 8'h7; tick(); w_v_i = '0;
    r_tag_i = 8'h7; #1; chk("dup_match", 32'(r_match_o), 32'b0011);
    r_v_i = 1'b0; #1; chk("rv0_match", 32'(r_match_o), 32'b0000);
    r_v_i = 1'b1;
    w_v_i = 4'b0011; w_set_not_clear_i = 1'b0; tick(); w_v_i = '0; #1;
    chk("mclr_empty", 32'(w_empty_o), 32'b0011);
    chk("mclr_match", 32'(r_match_o), 32'b0000);
    snoop_addr_i = 2'd1; #1; chk("mclr_snoop", 32'(snoop_tag_o), 32'h7);

    // non-power-of-two array: out-of-range snoop returns zero
    w_v3 = 3'b111; w_set_not_clear_i = 1'b1; w_tag_i = 8'h3C; tick(); w_v3 = '0;
    snoop_addr3 = 2'd2; #1; chk("np2_snoop2", 32'(snoop_tag3), 32'h3C);
    snoop_addr3 = 2'd3; #1; chk("np2_snoop3", 32'(snoop_tag3), 32'h0);
    r_tag_i = 8'h3C; #1; chk("np2_match", 32'(r_match3), 32'b111);

    // reset beats a same-cycle write
    reset_i = 1'b1; w_v_i = 4'b0001; w_set_not_clear_i = 1'b1; w_tag_i = 8'h99;
    tick();
    reset_i = 1'b0; w_v_i = '0; snoop_addr_i = 2'd0; r_tag_i = '0; #1;
    chk("rstw_empty", 32'(w_empty_o), 32'hF);
    chk("rstw_snoop0", 32'(snoop_tag_o), 32'h0);
    chk("rstw_match", 32'(r_match_o), 32'h0);
    snoop_addr_i = 2'd3; #1; chk("rstw_snoop3", 32'(snoop_tag_o), 32'h0);
    chk("rstw_empty3", 32'(w_empty3), 32'b111);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cam_tag_array_snoop.md
# cam_tag_array_snoop

Single-clock content-addressable tag array of `els_p` entries, each holding a `width_p`-bit tag and a valid bit. It provides:
- a per-entry write/clear port, with per-entry empty status;
- an asynchronous match (lookup) port;
- an asynchronous snoop port that reads the tag at a binary address.

It is the storage core of the coverage collector. The collector uses the match port to suppress duplicate entries, and the snoop port to drain stored tags in index order.

## Interface
Clocking and reset (already decided): one clock `clk_i`; reset `reset_i` is synchronous and active-high.

Parameters:
- `width_p`, default 32: tag width in bits, at least 1.
- `els_p`, default 16: number of entries, at least 1.
- `lg_els_lp` (derived): `max(1, ceil(log2(els_p)))`; this is the snoop address width.

Ports:
- `clk_i` (in, 1): clock; all state updates on its rising edge.
- `reset_i` (in, 1): synchronous active-high reset.
- `w_v_i` (in, `els_p`): per-entry write enable; any number of bits may be set.
- `w_set_not_clear_i` (in, 1): 1 = set the entry (load tag, mark valid); 0 = clear the entry (mark invalid).
- `w_tag_i` (in, `width_p`): tag loaded into every set entry.
- `w_empty_o` (out, `els_p`): bit k = 1 when entry k is invalid.
- `r_v_i` (in, 1): lookup enable.
- `r_tag_i` (in, `width_p`): lookup tag.
- `r_match_o` (out, `els_p`): bit k = 1 when the lookup hits entry k.
- `snoop_addr_i` (in, `lg_els_lp`): binary entry index to read.
- `snoop_tag_o` (out, `width_p`): tag stored at `snoop_addr_i`.

## Operation
State per entry k: `valid[k]` and `tag[k]`.

Reset:
- When `reset_i`=1 at a rising edge, all `valid` bits become 0 and all `tag` entries become 0.
- Reset overrides any write in the same cycle.

Write (at a rising edge, `reset_i`=0), for each k with `w_v_i[k]`=1:
- Set (`w_set_not_clear_i`=1): `tag[k]` gets `w_tag_i` and `valid[k]` gets 1. Overwriting a valid entry is allowed.
- Clear (`w_set_not_clear_i`=0): `valid[k]` gets 0 and `tag[k]` is retained. Clearing an already-empty entry is a no-op.
- Entries with `w_v_i[k]`=0 are unchanged.
- When `w_v_i` is all zero, nothing changes regardless of the other write inputs.

Empty status:
- `w_empty_o[k] = ~valid[k]`, purely combinational from state.

Match:
- `r_match_o[k] = r_v_i & valid[k] & (tag[k] == r_tag_i)`, combinational.
- Multiple bits may be set if duplicate tags are stored.
- `r_v_i`=0 forces `r_match_o` to all zeros.

Snoop:
- `snoop_tag_o = tag[snoop_addr_i]`, combinational, independent of `valid`. A cleared entry still returns its last tag.
- An address greater than or equal to `els_p` (non-power-of-two `els_p`) returns all zeros.

Simultaneous read and write:
- Match, empty and snoop outputs reflect state before the edge.
- There is no write-to-read forwarding in the same cycle.

Reset mid-operation:
- Takes effect at the next edge with `reset_i`=1.
- Outputs then show all empty, no match, and snoop returns 0.

## Timing
- Write latency: 1 cycle. Effects are visible on `w_empty_o`, `r_match_o` and `snoop_tag_o` immediately after the capturing edge.
- Read latency: 0 cycles. All outputs are combinational from current state and current inputs.
- There is no handshake; every write-enabled cycle is accepted.
- Values after reset:
  - `w_empty_o` = all ones.
  - `r_match_o` = 0, for any `r_tag_i`, including `r_tag_i`=0 with `r_v_i`=1, because no entry is valid.
  - `snoop_tag_o` = 0.
- Full condition (`w_empty_o`=0) and empty condition (`w_empty_o` all ones) are not flagged separately. The client derives them from `w_empty_o`.

## Test plan
1. **Reset state.** Apply reset, then `r_v_i`=1, `r_tag_i`=0, `snoop_addr_i`=0.
   - Required: `w_empty_o`=all ones, `r_match_o`=0, `snoop_tag_o`=0.
2. **Fill and lookup.** With `els_p`=4, set entries 0..3 one per cycle with tags 0xA, 0xB, 0xC, 0xD.
   - Required: `w_empty_o` goes 1110→1100→1000→0000.
   - Lookup 0xC gives `r_match_o`=0100. Lookup 0xE gives 0000.
   - Snoop address 3 gives 0xD.
3. **Clear retains tag.** Clear entry 2.
   - Required: `w_empty_o`=0100.
   - Lookup 0xC gives 0000. Snoop address 2 still gives 0xC.
4. **Same-cycle write and read.** In one cycle, set entry 2 with 0x5 while looking up 0x5.
   - Required: `r_match_o`=0000 in that cycle and 0100 in the next cycle.
5. **Multi-hot write and duplicates.** Set `w_v_i`=0011 with tag 0x7.
   - Required: lookup 0x7 gives `r_match_o`=0011.
   - Then `w_v_i`=0011 with clear gives `w_empty_o`=0011 on the low bits.
6. **Reset beats write.** Assert `reset_i` together with a set of entry 0.
   - Required: entry 0 is empty afterwards and `snoop_tag_o` at address 0 is 0.
